axis_pkt_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-Stream output, such as the line-side datapath feeding the width converter, between C_NUM_PORTS AXI-Stream requesters on the clk_line domain. A grant is held from a packet's first beat through its TLAST beat, so beats from different requesters are never interleaved. A per-port enable mask allows software to fence ports. A wrapping packet counter is exposed for status.

---
 rtl/axis_pkt_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_axis_pkt_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: merges C_NUM_PORTS AXI-Stream requesters
// onto one output and holds each grant from the first beat through TLAST.
module axis_pkt_rr_arbiter #(
  parameter int C_NUM_PORTS   = 4,
  parameter int C_WIDTH_TDATA = 256,
  parameter int C_WIDTH_TKEEP = C_WIDTH_TDATA / 8
) (
  input  logic                               clk_line,
  input  logic                               clk_line_rst,
  input  logic [C_NUM_PORTS-1:0]             in_TVALID,
  output logic [C_NUM_PORTS-1:0]             in_TREADY,
  input  logic [C_NUM_PORTS*C_WIDTH_TDATA-1:0] in_TDATA,
  input  logic [C_NUM_PORTS*C_WIDTH_TKEEP-1:0] in_TKEEP,
  input  logic [C_NUM_PORTS-1:0]             in_TLAST,
  input  logic [C_NUM_PORTS-1:0]             port_enable,
  output logic                               out_TVALID,
  input  logic                               out_TREADY,
  output logic [C_WIDTH_TDATA-1:0]           out_TDATA,
  output logic [C_WIDTH_TKEEP-1:0]           out_TKEEP,
  output logic                               out_TLAST,
  output logic                               grant_valid,
  output logic [2:0]                         grant_idx,
  output logic [31:0]                        pkt_count
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t      state_q;
  logic [2:0]  grant_idx_q;
  logic [2:0]  last_idx_q;
  logic [31:0] pkt_count_q;
  logic [31:0] pkt_count_d;

  logic [C_NUM_PORTS-1:0]   elig;
  logic                     pick_found;
  logic [2:0]               pick_idx;
  logic                     sel_vld;
  logic [C_WIDTH_TDATA-1:0] sel_data;
  logic [C_WIDTH_TKEEP-1:0] sel_keep;
  logic                     sel_last;
  logic                     granted;
  logic                     release_pkt;

  function automatic logic [3:0] wrap_add(input logic [2:0] base, input int unsigned k);
    logic [3:0] s;
    s = {1'b0, base} + 4'(k);
    if (s >= 4'(C_NUM_PORTS)) s = s - 4'(C_NUM_PORTS);
    return s;
  endfunction

  assign elig = in_TVALID & port_enable;

  // Scan from farthest to nearest so the nearest eligible port after last_idx wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_idx_q;
    for (int k = C_NUM_PORTS; k >= 1; k--) begin
      for (int j = 0; j < C_NUM_PORTS; j++) begin
        if (wrap_add(last_idx_q, k) == 4'(j) && elig[j]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    sel_last = 1'b0;
    for (int j = 0; j < C_NUM_PORTS; j++) begin
      if (grant_idx_q == 3'(j)) begin
        sel_vld  = in_TVALID[j];
        sel_data = in_TDATA[j*C_WIDTH_TDATA +: C_WIDTH_TDATA];
        sel_keep = in_TKEEP[j*C_WIDTH_TKEEP +: C_WIDTH_TKEEP];
        sel_last = in_TLAST[j];
      end
    end
  end

  assign granted    = (state_q == S_GRANT);
  assign out_TVALID = granted & sel_vld;
  assign out_TDATA  = granted ? sel_data : '0;
  assign out_TKEEP  = granted ? sel_keep : '0;
  assign out_TLAST  = granted & sel_last;

  always_comb begin
    in_TREADY = '0;
    for (int j = 0; j < C_NUM_PORTS; j++) begin
      in_TREADY[j] = granted && (grant_idx_q == 3'(j)) && out_TREADY;
    end
  end

  assign release_pkt = out_TVALID & out_TREADY & out_TLAST;
  assign pkt_count_d = pkt_count_q + 32'd1;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      state_q     <= S_IDLE;
      grant_idx_q <= 3'd0;
      last_idx_q  <= 3'(C_NUM_PORTS - 1);
      pkt_count_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx_q <= pick_idx;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_pkt) begin
            last_idx_q  <= grant_idx_q;
            pkt_count_q <= pkt_count_d;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_valid = granted;
  assign grant_idx   = grant_idx_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomized bench for axis_pkt_rr_arbiter against a packet-level round-robin
// reference model; directed phases cover the listed corner cases.
module tb_axis_pkt_rr_arbiter;

  localparam int N = 4;
  localparam int W = 256;
  localparam int K = W / 8;

  logic             clk_line = 1'b0;
  logic             clk_line_rst;
  logic [N-1:0]     in_TVALID;
  logic [N-1:0]     in_TREADY;
  logic [N*W-1:0]   in_TDATA;
  logic [N*K-1:0]   in_TKEEP;
  logic [N-1:0]     in_TLAST;
  logic [N-1:0]     port_enable;
  logic             out_TVALID;
  logic             out_TREADY;
  logic [W-1:0]     out_TDATA;
  logic [K-1:0]     out_TKEEP;
  logic             out_TLAST;
  logic             grant_valid;
  logic [2:0]       grant_idx;
  logic [31:0]      pkt_count;

  always #5 clk_line = ~clk_line;

  axis_pkt_rr_arbiter #(.C_NUM_PORTS(N), .C_WIDTH_TDATA(W), .C_WIDTH_TKEEP(K)) dut (
    .clk_line(clk_line), .clk_line_rst(clk_line_rst),
    .in_TVALID(in_TVALID), .in_TREADY(in_TREADY), .in_TDATA(in_TDATA),
    .in_TKEEP(in_TKEEP), .in_TLAST(in_TLAST), .port_enable(port_enable),
    .out_TVALID(out_TVALID), .out_TREADY(out_TREADY), .out_TDATA(out_TDATA),
    .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .pkt_count(pkt_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // stimulus controls
  logic [N-1:0] act, en;
  int vld_pct, rdy_pct, len_lo, len_hi;
  bit rst_now;

  // per-port packet sources
  logic [W-1:0] src_data [N];
  logic [K-1:0] src_keep [N];
  int           src_rem  [N];
  logic [N-1:0] vld;

  // reference model: is a packet in flight, whose, who finished last, how many done
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic [31:0] m_count;

  task automatic new_beat(input int i);
    for (int w = 0; w < W / 32; w++) src_data[i][w*32 +: 32] = $urandom;
    src_keep[i] = $urandom;
  endtask

  task automatic cycle();
    bit          hs, found, n_busy;
    int          n_owner, n_last;
    logic [31:0] n_count;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      if (act[i] && src_rem[i] == 0) begin
        src_rem[i] = $urandom_range(len_hi, len_lo);
        new_beat(i);
      end
      vld[i] = act[i] && (src_rem[i] > 0) && ($urandom_range(99) < vld_pct);
      in_TDATA[i*W +: W] = src_data[i];
      in_TKEEP[i*K +: K] = src_keep[i];
      in_TLAST[i] = (src_rem[i] == 1);
    end
    in_TVALID    = vld;
    out_TREADY   = ($urandom_range(99) < rdy_pct);
    port_enable  = en;
    clk_line_rst = rst_now;
    #1;
    exp_rdy = '0;
    if (m_busy) exp_rdy[m_owner] = out_TREADY;
    hs = m_busy && vld[m_owner] && out_TREADY;
    if (chk_on) begin
      check("out_tvalid", out_TVALID, m_busy && vld[m_owner]);
      check("in_tready", in_TREADY, exp_rdy);
      check("grant_valid", grant_valid, m_busy);
      check("pkt_count", pkt_count, m_count);
      if (m_busy) check("grant_idx", grant_idx, m_owner);
      if (m_busy && vld[m_owner]) begin
        check("out_tdata", out_TDATA, src_data[m_owner]);
        check("out_tkeep", out_TKEEP, src_keep[m_owner]);
        check("out_tlast", out_TLAST, src_rem[m_owner] == 1);
      end
      if (!m_busy) check("idle_tdata", out_TDATA, '0);
    end
    n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_count = m_count;
    if (rst_now) begin
      n_busy = 0; n_owner = 0; n_last = N - 1; n_count = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (!found && en[p] && vld[p]) begin
          found = 1; n_busy = 1; n_owner = p;
        end
      end
    end else if (hs && src_rem[m_owner] == 1) begin
      n_busy = 0; n_last = m_owner; n_count = m_count + 1;
    end
    if (hs) begin
      src_rem[m_owner]--;
      if (src_rem[m_owner] > 0) new_beat(m_owner);
    end
    @(posedge clk_line);
    #1;
    m_busy = n_busy; m_owner = n_owner; m_last = n_last; m_count = n_count;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_rem[i] = 0; src_data[i] = '0; src_keep[i] = '0;
    end
    m_busy = 0; m_owner = 0; m_last = N - 1; m_count = 0;
    act = '0; en = '1; vld_pct = 100; rdy_pct = 100; len_lo = 1; len_hi = 1;
    rst_now = 1;
    run(2);
    chk_on = 1;
    run(1);
    rst_now = 0;
    check("rst_grant_idx", grant_idx, 3'd0);
    check("rst_pkt_count", pkt_count, 32'd0);

    // single 3-beat packet on port 0
    act = 4'b0001; len_lo = 3; len_hi = 3;
    run(4);
    act = '0;
    run(3);
    check("p0_pkt_count", pkt_count, 32'd1);

    // all ports busy with 2-beat packets: order 0,1,2,3,... with one bubble
    act = '1; len_lo = 2; len_hi = 2;
    run(26);

    // backpressure
    rdy_pct = 50;
    run(40);

    // enable mask, then fence port 1
    rdy_pct = 100; en = 4'b1010;
    run(30);
    en = 4'b1000;
    run(20);

    // granted port dropping valid
    en = '1; vld_pct = 60; rdy_pct = 70; len_lo = 1; len_hi = 6;
    run(200);

    // reset mid-packet
    vld_pct = 100; rdy_pct = 100; len_lo = 4; len_hi = 4;
    run(5);
    rst_now = 1;
    run(1);
    rst_now = 0;
    check("midrst_pkt_count", pkt_count, 32'd0);
    check("midrst_grant_valid", grant_valid, 1'b0);
    check("midrst_out_tvalid", out_TVALID, 1'b0);
    run(20);

    // long random soak
    for (int b = 0; b < 30; b++) begin
      vld_pct = $urandom_range(100, 20);
      rdy_pct = $urandom_range(100, 20);
      len_lo = 1; len_hi = $urandom_range(6, 1);
      act = $urandom; act = act | 4'b0001;
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(99) < 5) en = $urandom;
        rst_now = ($urandom_range(999) < 3);
        cycle();
      end
    end
    rst_now = 0;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
